// File: rtl/mul_iter.sv
// Iterative 32x32 shift-add multiplier for the EX stage: radix-2 on operand
// magnitudes with a final two's-complement sign fix, returning {HI, LO}.
module mul_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_mul_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        i_stall,
  input  logic        d_stall,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    ON   = 2'd1,
    FIX  = 2'd2,
    END  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic        neg_q, neg_d;
  logic [63:0] result_d;
  logic        ready_d;

  logic        stall;
  logic        accept;
  logic        operand_zero;
  logic        neg_in;
  logic [31:0] mag1;
  logic [31:0] mag2;

  // The stall is a clock enable, so every register below shares it.
  assign stall        = i_stall | d_stall;
  assign accept       = start_i & ~annul_i;
  assign operand_zero = (opdata1_i == 32'd0) || (opdata2_i == 32'd0);
  assign neg_in       = signed_mul_i & (opdata1_i[31] ^ opdata2_i[31]);
  assign mag1         = (signed_mul_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign mag2         = (signed_mul_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      neg_q    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else if (!stall) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      result_o <= result_d;
      ready_o  <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE: begin
        if (accept) begin
          state_d = operand_zero ? END : ON;
        end
      end
      ON: begin
        if (annul_i) begin
          state_d = FREE;
        end else if (cnt_q == 6'd32) begin
          state_d = FIX;
        end
      end
      FIX: state_d = END;
      END: begin
        if (!start_i) begin
          state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  // Result is published one edge after reaching END and held while start is high.
  always_comb begin
    ready_d  = 1'b0;
    result_d = 64'd0;
    if (state_q == END && start_i) begin
      ready_d  = 1'b1;
      result_d = acc_q;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    case (state_q)
      FREE: begin
        if (accept) begin
          acc_d = 64'd0;
          if (operand_zero) begin
            neg_d = 1'b0;
          end else begin
            neg_d    = neg_in;
            mcand_d  = {32'd0, mag1};
            mplier_d = mag2;
            cnt_d    = 6'd0;
          end
        end
      end
      ON: begin
        if (!annul_i && cnt_q != 6'd32) begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 6'd1;
        end
      end
      FIX: begin
        if (neg_q) begin
          acc_d = ~acc_q + 64'd1;
        end
        cnt_d = 6'd0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter: stimulus pushes expected product and latency,
// a monitor pops and compares on every rising edge of ready_o.
module tb_mul_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_mul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic        i_stall;
  logic        d_stall;
  logic [63:0] result_o;
  logic        ready_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  logic ready_prev = 1'b0;

  logic [63:0] exp_res_q[$];
  int          exp_lat_q[$];
  int          exp_start_q[$];

  mul_iter dut (
    .clk          (clk),
    .rst          (rst),
    .signed_mul_i (signed_mul_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .i_stall      (i_stall),
    .d_stall      (d_stall),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge of ready_o.
  initial begin
    logic [63:0] r;
    int          l;
    int          s;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ready_prev = 1'b0;
      end else begin
        if (ready_o && !ready_prev) begin
          if (exp_res_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_ready: got ready_o=1 with result 0x%016h, expected no result", result_o);
          end else begin
            r = exp_res_q.pop_front();
            l = exp_lat_q.pop_front();
            s = exp_start_q.pop_front();
            checkOutput("product", result_o, r);
            checkOutput("latency", 64'(cyc - s), 64'(l));
          end
        end
        ready_prev = ready_o;
      end
    end
  end

  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] expected, input int lat, input int stalls,
                               input bit release_by_reset);
    int  stalls_left;
    int  active;
    bit  got;
    bit  stalled;
    @(negedge clk);
    signed_mul_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_res_q.push_back(expected);
    exp_lat_q.push_back(lat);
    exp_start_q.push_back(cyc + 1);
    stalls_left = stalls;
    active      = 0;
    got         = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      stalled = 1'b0;
      if (stalls_left > 0 && ($urandom_range(0, 2) != 0 || active >= 20)) begin
        if ($urandom_range(0, 1) == 1) i_stall = 1'b1;
        else d_stall = 1'b1;
        stalls_left--;
        stalled = 1'b1;
      end
      @(negedge clk);
      i_stall = 1'b0;
      d_stall = 1'b0;
      if (!stalled) active++;
      if (ready_o) got = 1'b1;
    end
    if (!got) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL ready_timeout: got ready_o=0 after 200 cycles, expected 1 (op 0x%08h x 0x%08h)", a, b);
    end
    repeat (3) @(negedge clk);
    checkOutput("hold_ready", 64'(ready_o), 64'd1);
    checkOutput("hold_result", result_o, expected);
    if (release_by_reset) begin
      #2 rst = 1'b1;
      #1;
      checkOutput("async_reset_ready", 64'(ready_o), 64'd0);
      checkOutput("async_reset_result", result_o, 64'd0);
      @(negedge clk);
      start_i = 1'b0;
      rst     = 1'b0;
    end else begin
      start_i = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("release_ready", 64'(ready_o), 64'd0);
      checkOutput("release_result", result_o, 64'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    signed_mul_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    i_stall      = 1'b0;
    d_stall      = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_ready", 64'(ready_o), 64'd0);
    checkOutput("reset_result", result_o, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 35, 0, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 35, 0, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 35, 0, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 35, 0, 1'b0);
    applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 35, 0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, 1, 0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0007, 32'h0000_0000, 64'h0000_0000_0000_0000, 1, 0, 1'b0);

    // Annul at iteration 10; nothing is queued, so any ready pulse is caught.
    @(negedge clk);
    signed_mul_i = 1'b0;
    opdata1_i    = 32'd5;
    opdata2_i    = 32'd6;
    start_i      = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (45) @(negedge clk);
    checkOutput("annul_ready", 64'(ready_o), 64'd0);
    checkOutput("annul_result", result_o, 64'd0);
    applyStimulus(1'b0, 32'd5, 32'd6, 64'd30, 35, 0, 1'b0);

    applyStimulus(1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 52, 17, 1'b0);

    // Reset while a result is being held.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 35, 0, 1'b1);

    // Reset at iteration 20 of an operation that is never queued.
    @(negedge clk);
    signed_mul_i = 1'b0;
    opdata1_i    = 32'h0001_0003;
    opdata2_i    = 32'h0000_0005;
    start_i      = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midop_reset_ready", 64'(ready_o), 64'd0);
    checkOutput("midop_reset_result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 32'h0000_0002, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 35, 0, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(exp_res_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
